filtro_sensores_nivel: RTL and testbench

//  Upstream conditioning stage for the water-tank controller. Synchronises, debounces and plausibility-checks
//  the two raw 5-bit level-sensor vectors (inverted logic: 0 = water present) before the controller FSM and
//  the display decoders use them. Only stable thermometer-coded patterns are forwarded; invalid ones raise a fault.

---
 rtl/filtro_sensores_nivel.sv | 175 +++++++++++++++++
 tb/tb_filtro_sensores_nivel.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/filtro_sensores_nivel.sv
// filtro_sensores_nivel: synchroniser, debouncer and thermometer plausibility
// check for the two 5-bit level-sensor vectors (inverted logic, 0 = wet).
// Optional feature macro: FILTRO_FALHA_SEGURA_EN. When it is defined, a faulted
// channel drives a safe pattern (lower 5'b11110, upper 5'b00000) instead of
// holding its last valid value.
// Output semantics: atualizado_x is a one-clock pulse, registered alongside
// sensores_x, raised only when a valid commit changes the forwarded value.
// There is no back-pressure; the consumer must sample the pulse every clock.

module filtro_canal #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
`ifdef FILTRO_FALHA_SEGURA_EN
  ,
  parameter logic [4:0] SAFE_VAL = 5'b11111
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] raw,
  output logic [4:0] filt,
  output logic       atualizado,
  output logic       falha,
  output logic       commit_inv
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [4:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic             commit;
  logic             cand_valid;

  // A commit happens exactly once per stable candidate: the counter saturates
  // at CNT_MAX, so CNT_LAST is passed only once until the candidate changes.
  assign commit     = (sync2 == cand) && (cnt == CNT_LAST);
  assign commit_inv = commit && !cand_valid;

  // Only inverted thermometer codes are physically plausible.
  always_comb begin
    cand_valid = 1'b0;
    case (cand)
      5'b11111, 5'b11110, 5'b11100,
      5'b11000, 5'b10000, 5'b00000: cand_valid = 1'b1;
      default:                      cand_valid = 1'b0;
    endcase
  end

  // Two-flop synchroniser; the raw input feeds the first flop directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 5'b11111;
      sync2 <= 5'b11111;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Candidate tracking and saturating stability counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand <= 5'b11111;
      cnt  <= '0;
    end else if (sync2 != cand) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (cnt < CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Output register: forward valid commits, flag invalid ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt       <= 5'b11111;
      atualizado <= 1'b0;
      falha      <= 1'b0;
    end else begin
      atualizado <= 1'b0;
      if (commit) begin
        if (cand_valid) begin
          filt       <= cand;
          falha      <= 1'b0;
          atualizado <= (cand != filt);
        end else begin
          falha <= 1'b1;
`ifdef FILTRO_FALHA_SEGURA_EN
          filt  <= SAFE_VAL;
`else
          filt  <= filt;
`endif
        end
      end
    end
  end

endmodule

module filtro_sensores_nivel #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int EVT_W           = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       sensores_inf_raw,
  input  logic [4:0]       sensores_sup_raw,
  output logic [4:0]       sensores_inf,
  output logic [4:0]       sensores_sup,
  output logic             atualizado_inf,
  output logic             atualizado_sup,
  output logic             falha_inf,
  output logic             falha_sup,
  output logic [EVT_W-1:0] eventos_falha
);

  logic             inv_inf;
  logic             inv_sup;
  logic [1:0]       n_inv;
  logic [EVT_W:0]   soma;

  filtro_canal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
`ifdef FILTRO_FALHA_SEGURA_EN
    ,
    .SAFE_VAL       (5'b11110)
`endif
  ) u_inf (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw       (sensores_inf_raw),
    .filt      (sensores_inf),
    .atualizado(atualizado_inf),
    .falha     (falha_inf),
    .commit_inv(inv_inf)
  );

  filtro_canal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
`ifdef FILTRO_FALHA_SEGURA_EN
    ,
    .SAFE_VAL       (5'b00000)
`endif
  ) u_sup (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw       (sensores_sup_raw),
    .filt      (sensores_sup),
    .atualizado(atualizado_sup),
    .falha     (falha_sup),
    .commit_inv(inv_sup)
  );

  // Up to two invalid commits per clock; sum with one spare bit to detect overflow.
  assign n_inv = {1'b0, inv_inf} + {1'b0, inv_sup};
  assign soma  = {1'b0, eventos_falha} + {{(EVT_W-1){1'b0}}, n_inv};

  // Saturating fault-event counter shared by both channels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eventos_falha <= '0;
    end else if (soma[EVT_W]) begin
      eventos_falha <= '1;
    end else begin
      eventos_falha <= soma[EVT_W-1:0];
    end
  end

endmodule

// File: tb/tb_filtro_sensores_nivel.sv
// Bench for filtro_sensores_nivel with DEBOUNCE_CYCLES=4, EVT_W=3.
// Reference model: each channel is a run-length tracker over the synchronised
// sample stream; a commit fires when a value has been seen DEBOUNCE_CYCLES+1
// edges in a row (the reset pattern counts as already seen once).

module tb_filtro_sensores_nivel;

  localparam int D     = 4;
  localparam int CW    = 3;
  localparam int EW    = 3;
  localparam int EVMAX = (1 << EW) - 1;

  logic          clk;
  logic          reset_n;
  logic [4:0]    sensores_inf_raw;
  logic [4:0]    sensores_sup_raw;
  logic [4:0]    sensores_inf;
  logic [4:0]    sensores_sup;
  logic          atualizado_inf;
  logic          atualizado_sup;
  logic          falha_inf;
  logic          falha_sup;
  logic [EW-1:0] eventos_falha;

  int total;
  int bad;

  // model state, index 0 = lower tank, 1 = upper tank
  logic [4:0] m_s1[2];
  logic [4:0] m_s2[2];
  logic [4:0] m_v[2];
  int         m_r[2];
  logic [4:0] m_out[2];
  logic       m_falha[2];
  logic       m_upd[2];
  int         m_ev;

  filtro_sensores_nivel #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW),
    .EVT_W          (EW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sensores_inf_raw(sensores_inf_raw),
    .sensores_sup_raw(sensores_sup_raw),
    .sensores_inf    (sensores_inf),
    .sensores_sup    (sensores_sup),
    .atualizado_inf  (atualizado_inf),
    .atualizado_sup  (atualizado_sup),
    .falha_inf       (falha_inf),
    .falha_sup       (falha_sup),
    .eventos_falha   (eventos_falha)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit is_thermo(input logic [4:0] x);
    for (int k = 0; k <= 5; k++) begin
      if (x == 5'(5'b11111 << k)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 9) < 7) return 5'(5'b11111 << $urandom_range(0, 5));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c]    = 5'b11111;
      m_s2[c]    = 5'b11111;
      m_v[c]     = 5'b11111;
      m_r[c]     = 1;
      m_out[c]   = 5'b11111;
      m_falha[c] = 1'b0;
      m_upd[c]   = 1'b0;
    end
    m_ev = 0;
  endtask

  task automatic model_chan(input int c, input logic [4:0] raw, inout int n);
    logic [4:0] s;
    s = m_s2[c];
    m_upd[c] = 1'b0;
    if (s == m_v[c]) begin
      if (m_r[c] < 100) m_r[c]++;
    end else begin
      m_v[c] = s;
      m_r[c] = 1;
    end
    if (m_r[c] == D + 1) begin
      if (is_thermo(s)) begin
        m_upd[c]   = (s != m_out[c]);
        m_out[c]   = s;
        m_falha[c] = 1'b0;
      end else begin
        m_falha[c] = 1'b1;
        n++;
`ifdef FILTRO_FALHA_SEGURA_EN
        m_out[c] = (c == 0) ? 5'b11110 : 5'b00000;
`endif
      end
    end
    m_s2[c] = m_s1[c];
    m_s1[c] = raw;
  endtask

  task automatic check_all();
    check("sensores_inf",   8'(sensores_inf),   8'(m_out[0]));
    check("sensores_sup",   8'(sensores_sup),   8'(m_out[1]));
    check("atualizado_inf", 8'(atualizado_inf), 8'(m_upd[0]));
    check("atualizado_sup", 8'(atualizado_sup), 8'(m_upd[1]));
    check("falha_inf",      8'(falha_inf),      8'(m_falha[0]));
    check("falha_sup",      8'(falha_sup),      8'(m_falha[1]));
    check("eventos_falha",  8'(eventos_falha),  8'(m_ev));
  endtask

  // drive raws, advance one edge, update the model, compare away from the edge
  task automatic step(input logic [4:0] ri, input logic [4:0] rs);
    int n;
    sensores_inf_raw = ri;
    sensores_sup_raw = rs;
    @(posedge clk);
    n = 0;
    model_chan(0, ri, n);
    model_chan(1, rs, n);
    m_ev = (m_ev + n > EVMAX) ? EVMAX : m_ev + n;
    #1;
    check_all();
  endtask

  task automatic hold(input logic [4:0] ri, input logic [4:0] rs, input int cycles);
    for (int i = 0; i < cycles; i++) step(ri, rs);
  endtask

  initial begin
    int         hi;
    int         hs;
    logic [4:0] vi;
    logic [4:0] vs;
    total = 0;
    bad   = 0;

    // reset state
    reset_n          = 1'b0;
    sensores_inf_raw = 5'b11111;
    sensores_sup_raw = 5'b11111;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    check("reset_inf_const", 8'(sensores_inf), 8'h1f);
    #4 reset_n = 1'b1;

    // 1: held change reaches the output on the 7th edge, one pulse
    hold(5'b11100, 5'b11111, 6);
    check("t1_before", 8'(sensores_inf), 8'h1f);
    step(5'b11100, 5'b11111);
    check("t1_value", 8'(sensores_inf), 8'h1c);
    check("t1_pulse", 8'(atualizado_inf), 8'h1);
    step(5'b11100, 5'b11111);
    check("t1_pulse_end", 8'(atualizado_inf), 8'h0);

    // 2: short glitch on the upper channel is rejected
    hold(5'b11100, 5'b11110, 3);
    hold(5'b11100, 5'b11111, 10);
    check("t2_value", 8'(sensores_sup), 8'h1f);
    check("t2_falha", 8'(falha_sup), 8'h0);

    // 3: invalid pattern then recovery
    hold(5'b10110, 5'b11111, 8);
    check("t3_falha", 8'(falha_inf), 8'h1);
    check("t3_events", 8'(eventos_falha), 8'h1);
`ifdef FILTRO_FALHA_SEGURA_EN
    check("t3_safe", 8'(sensores_inf), 8'h1e);
`else
    check("t3_hold", 8'(sensores_inf), 8'h1c);
`endif
    hold(5'b11000, 5'b11111, 8);
    check("t3_clear", 8'(falha_inf), 8'h0);
    check("t3_value", 8'(sensores_inf), 8'h18);

    // 4: simultaneous invalid commits add two, then saturate
    hold(5'b01010, 5'b01010, 8);
    check("t4_plus2", 8'(eventos_falha), 8'h3);
    hold(5'b10101, 5'b10101, 8);
    check("t4_five", 8'(eventos_falha), 8'h5);
    hold(5'b01010, 5'b01010, 8);
    check("t4_seven", 8'(eventos_falha), 8'h7);
    hold(5'b10101, 5'b10101, 8);
    check("t4_sat", 8'(eventos_falha), 8'h7);

    // 5: upper channel fault after a valid commit
    hold(5'b11000, 5'b11000, 8);
    check("t5_valid", 8'(sensores_sup), 8'h18);
    hold(5'b11000, 5'b01111, 8);
    check("t5_falha", 8'(falha_sup), 8'h1);
`ifdef FILTRO_FALHA_SEGURA_EN
    check("t5_safe", 8'(sensores_sup), 8'h00);
`else
    check("t5_hold", 8'(sensores_sup), 8'h18);
`endif

    // 6: asynchronous reset in the middle of a debounce
    hold(5'b10000, 5'b11111, 4);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("t6_async_inf", 8'(sensores_inf), 8'h1f);
    check("t6_async_ev", 8'(eventos_falha), 8'h0);
    #3 reset_n = 1'b1;
    hold(5'b10000, 5'b11111, 6);
    check("t6_before", 8'(sensores_inf), 8'h1f);
    step(5'b10000, 5'b11111);
    check("t6_value", 8'(sensores_inf), 8'h10);
    check("t6_pulse", 8'(atualizado_inf), 8'h1);

    // random phase: independent hold lengths around the debounce window
    hi = 0;
    hs = 0;
    vi = 5'b11111;
    vs = 5'b11111;
    for (int t = 0; t < 600; t++) begin
      if (hi == 0) begin
        vi = pick();
        hi = $urandom_range(1, 9);
      end
      if (hs == 0) begin
        vs = pick();
        hs = $urandom_range(1, 9);
      end
      step(vi, vs);
      hi--;
      hs--;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
